store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//  Posted-store FIFO between the MEM-stage control (upstream) and Data_Memory (downstream).
//  Stores retire from the pipeline in one cycle and drain to memory only in cycles with no pipeline memory op.
//  Loads read through the buffer and see buffered data, so program order is preserved for one hart.
// PARAMETERS
//  DEPTH   4   number of buffered stores, power of two, >=2
//  AW      32  address width; full-width compare, no partial-word stores
//  DW      32  data width
// PORTS
//  clk_i        in   1   single clock, rising edge
//  rst_i        in   1   asynchronous, active-low reset
//  MemWrite_i   in   1   pipeline store request this cycle
//  MemRead_i    in   1   pipeline load request this cycle
//  Address_i    in   AW  request word address
//  Writedata_i  in   DW  store data
//  Readdata_o   out  DW  load result, combinational, valid when MemRead_i=1 and Stall_o=0
//  Stall_o      out  1   combinational; hold the MEM stage, request not accepted this cycle
//  Empty_o      out  1   registered count==0 (fence / halt check)
//  mem_addr_o   out  AW  to Data_Memory Address_i
//  mem_wdata_o  out  DW  to Data_Memory Writedata_i
//  mem_write_o  out  1   to Data_Memory MemWrite_i, one-cycle pulse per drained entry
//  mem_read_o   out  1   to Data_Memory MemRead_i
//  mem_rdata_i  in   DW  from Data_Memory Readdata_o (combinational read)
// BEHAVIOUR
//  State: entry[DEPTH]{addr,data}, head/tail ptr (log2 DEPTH, wrap mod DEPTH), count (log2 DEPTH + 1 bits).
//  Reset: count=0, ptrs=0, Empty_o=1. Pending entries are discarded, including on reset mid-drain.
//   Combinational outputs are 0 with no request.
//  Store with count<DEPTH: enqueued at tail on the edge; Stall_o=0. Store-to-memory latency >=1 cycle.
//  Store with count==DEPTH: Stall_o=1. The head drains this cycle; the store is accepted next cycle.
//  Drain: when count>0 and the port is free, drive mem_write_o=1, mem_addr_o/mem_wdata_o=head; dequeue on the edge.
//   The port is free when MemRead_i=0 and MemWrite_i=0, or when a stalled request leaves the port unused.
//   A forwarded load also leaves the port free.
//  Load with no address match: mem_read_o=1, mem_addr_o=Address_i, Readdata_o=mem_rdata_i. No drain that cycle.
//  Load matching a buffered entry: see STORE_FWD_EN.
//  Simultaneous enqueue+dequeue: count unchanged, both ptrs advance.
//  MemRead_i && MemWrite_i together: illegal. The store is honoured and the load is ignored.
//  Idle (no request, count==0): all mem_* outputs are 0.
//  Never drop, duplicate or reorder stores. mem_write_o is never asserted in the same cycle as mem_read_o.
// CONFIGURATION
//  STORE_FWD_EN defined: a matching load returns the YOUNGEST matching entry's data combinationally.
//   In that case Stall_o=0 and mem_read_o=0, and the head may drain in the same cycle.
//  STORE_FWD_EN undefined: a matching load raises Stall_o.
//   The buffer drains one entry per cycle until no entry matches, then the load reads memory.
// STRUCTURE
//  Package store_buffer_pkg: DEPTH/AW/DW defaults, PTR_W = $clog2(DEPTH), entry struct {addr,data}.
//   Also holds the ptr increment-with-wrap function.
//  One sub-module: store_buffer_match.
//   Inputs: entries, per-entry valid vector, head ptr, Address_i.
//   Outputs: hit plus youngest-hit index, using age-ordered priority from the tail backwards.
// TESTING
//  1. Reset, store 0x4=0xA, then idle -> mem_write_o next cycle, addr 0x4 data 0xA, Empty_o=1 after.
//  2. Stores 0x4,0x8,0xC,0x10, then a 5th store 0x14 (DEPTH=4) -> Stall_o=1 one cycle with head 0x4 drained.
//     The 0x14 store is accepted next cycle, and drain order in idle cycles is 0x8,0xC,0x10,0x14.
//  3. FWD_EN: store 0x8=0x11, store 0x8=0x22, load 0x8 -> Readdata_o=0x22 same cycle.
//     Stall_o=0 and mem_read_o=0 in that cycle.
//  4. No FWD_EN: stores 0x8=0x11, 0xC=0x33, then load 0xC -> Stall_o=1 for 2 cycles while both drain.
//     The load then returns 0x33 from memory.
//  5. Load 0x40 (no match) with 2 entries buffered -> mem_read_o=1, no mem_write_o that cycle, count stays 2.
//  6. 2 entries buffered, rst_i low mid-cycle -> Empty_o=1 immediately.
//     No mem_write_o after release; memory at those addresses is unchanged.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// ==========================================================================
// store_buffer_pkg: sizing constants, entry record and pointer helper.
// Rev 1.0
// ==========================================================================
`default_nettype none

package store_buffer_pkg;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  // DEPTH is a power of two, so natural overflow of PTR_W bits is the wrap.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return PTR_W'(ptr + 1'b1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/store_buffer_match.sv
// ==========================================================================
// store_buffer_match: address CAM over buffered stores, youngest hit wins.
// Rev 1.0
// ==========================================================================
`default_nettype none

module store_buffer_match
  import store_buffer_pkg::*;
(
  input  entry_t           entries [DEPTH],
  input  logic [DEPTH-1:0] valid,
  input  logic [PTR_W-1:0] head,
  input  logic [AW-1:0]    addr,
  output logic             hit,
  output logic [PTR_W-1:0] hit_idx
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest; the last match seen is the youngest one.
  always_comb begin
    hit     = 1'b0;
    hit_idx = head;
    idx     = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = PTR_W'(head + PTR_W'(k));
      if (valid[idx] && (entries[idx].addr == addr)) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/store_buffer.sv
// ==========================================================================
// store_buffer: posted-store FIFO in front of Data_Memory with load bypass.
// Optional STORE_FWD_EN: forward youngest matching store to loads. Rev 1.0
// ==========================================================================
`default_nettype none

module store_buffer
  import store_buffer_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          MemWrite_i,
  input  logic          MemRead_i,
  input  logic [AW-1:0] Address_i,
  input  logic [DW-1:0] Writedata_i,
  output logic [DW-1:0] Readdata_o,
  output logic          Stall_o,
  output logic          Empty_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          mem_write_o,
  output logic          mem_read_o,
  input  logic [DW-1:0] mem_rdata_i
);

  entry_t             entries [DEPTH];
  logic [PTR_W-1:0]   head, tail;
  logic [PTR_W:0]     count, count_nxt;
  logic               empty_q;
  logic [DEPTH-1:0]   valid;
  logic [PTR_W-1:0]   age;

  logic               hit;
  logic [PTR_W-1:0]   hit_idx;
  logic               full, is_store, is_load, store_stall, load_stall;
  logic               fwd, load_mem, port_free, drain, enq;

  always_comb begin
    valid = '0;
    age   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age      = PTR_W'(PTR_W'(i) - head);
      valid[i] = ({1'b0, age} < count);
    end
  end

  store_buffer_match u_match (
    .entries (entries),
    .valid   (valid),
    .head    (head),
    .addr    (Address_i),
    .hit     (hit),
    .hit_idx (hit_idx)
  );

  always_comb begin
    full        = (count == (PTR_W+1)'(DEPTH));
    is_store    = MemWrite_i;
    is_load     = MemRead_i & ~MemWrite_i;
    store_stall = is_store & full;
`ifdef STORE_FWD_EN
    load_stall  = 1'b0;
    fwd         = is_load & hit;
`else
    load_stall  = is_load & hit;
    fwd         = 1'b0;
`endif
    load_mem    = is_load & ~hit;
    // Stalled or forwarded requests never touch memory, so the head may drain.
    port_free   = ~(is_store | is_load) | store_stall | load_stall | fwd;
    drain       = port_free & (count != '0);
    enq         = is_store & ~full;
    count_nxt   = count + (PTR_W+1)'(enq) - (PTR_W+1)'(drain);

    Stall_o     = store_stall | load_stall;
    mem_read_o  = load_mem;
    mem_write_o = drain;
    mem_addr_o  = drain ? entries[head].addr : (load_mem ? Address_i : '0);
    mem_wdata_o = drain ? entries[head].data : '0;
    Readdata_o  = fwd ? entries[hit_idx].data : (load_mem ? mem_rdata_i : '0);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      empty_q <= 1'b1;
    end else begin
      if (enq)   tail <= ptr_inc(tail);
      if (drain) head <= ptr_inc(head);
      count   <= count_nxt;
      empty_q <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) entries[tail] <= '{addr: Address_i, data: Writedata_i};
  end

  assign Empty_o = empty_q;

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ==========================================================================
// tb_store_buffer: directed stimulus with scoreboarded drain/load checking.
// Rev 1.0
// ==========================================================================
`default_nettype none

module tb_store_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        MemWrite_i = 1'b0, MemRead_i = 1'b0;
  logic [31:0] Address_i = '0, Writedata_i = '0;
  logic [31:0] Readdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        Stall_o, Empty_o, mem_write_o, mem_read_o;

  store_buffer dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .MemWrite_i  (MemWrite_i),
    .MemRead_i   (MemRead_i),
    .Address_i   (Address_i),
    .Writedata_i (Writedata_i),
    .Readdata_o  (Readdata_o),
    .Stall_o     (Stall_o),
    .Empty_o     (Empty_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_write_o (mem_write_o),
    .mem_read_o  (mem_read_o),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Data memory model: unwritten words read back as 0xD000_0000 | address.
  logic [31:0] mem [64];
  logic [63:0] wr_valid = '0;
  assign mem_rdata_i = wr_valid[mem_addr_o[7:2]] ? mem[mem_addr_o[7:2]]
                                                 : (32'hD000_0000 | {24'b0, mem_addr_o[7:2], 2'b00});
  always @(posedge clk_i) begin
    if (rst_i && mem_write_o) begin
      mem[mem_addr_o[7:2]]      <= mem_wdata_o;
      wr_valid[mem_addr_o[7:2]] <= 1'b1;
    end
  end

  logic [31:0] exp_wa [$];
  logic [31:0] exp_wd [$];
  logic [31:0] exp_rd [$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_b(input string nm, input logic act, input logic exp);
    chk(nm, {31'b0, act}, {31'b0, exp});
  endtask

  // Monitor: every drained write and every completed load is popped and compared.
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (mem_write_o) begin
        chk_b("wr_excludes_rd", mem_read_o, 1'b0);
        if (exp_wa.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_drain: got addr 0x%0h data 0x%0h, expected none", mem_addr_o, mem_wdata_o);
        end else begin
          chk("drain_addr", mem_addr_o, exp_wa.pop_front());
          chk("drain_data", mem_wdata_o, exp_wd.pop_front());
        end
      end
      if (MemRead_i && !MemWrite_i && !Stall_o) begin
        if (exp_rd.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_load: got 0x%0h, expected none", Readdata_o);
        end else begin
          chk("load_data", Readdata_o, exp_rd.pop_front());
        end
      end
    end
  end

  task automatic drive(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    MemWrite_i  = we;
    MemRead_i   = re;
    Address_i   = a;
    Writedata_i = d;
  endtask

  task automatic next_cyc;
    @(posedge clk_i);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b0, a, d);
    exp_wa.push_back(a);
    exp_wd.push_back(d);
    @(negedge clk_i);
    chk_b("store_no_stall", Stall_o, 1'b0);
    next_cyc();
  endtask

  task automatic idle_until_empty;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 20 && !Empty_o; i++) next_cyc();
    chk_b("drained_empty", Empty_o, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int stalls;
    // Reset state
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk_b("rst_empty", Empty_o, 1'b1);
    chk_b("rst_stall", Stall_o, 1'b0);
    chk_b("rst_mem_write", mem_write_o, 1'b0);
    chk_b("rst_mem_read", mem_read_o, 1'b0);
    chk("rst_readdata", Readdata_o, 32'h0);
    next_cyc();
    rst_i = 1'b1;

    // 1: single store drains in the next idle cycle
    store(32'h4, 32'hA);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk_i);
    chk_b("t1_not_empty", Empty_o, 1'b0);
    chk_b("t1_drain", mem_write_o, 1'b1);
    next_cyc();
    chk_b("t1_empty_after", Empty_o, 1'b1);

    // 2: fill, stall on fifth store while the head drains
    store(32'h4,  32'h104);
    store(32'h8,  32'h108);
    store(32'hC,  32'h10C);
    store(32'h10, 32'h110);
    drive(1'b1, 1'b0, 32'h14, 32'h114);
    @(negedge clk_i);
    chk_b("t2_full_stall", Stall_o, 1'b1);
    chk_b("t2_drain_on_stall", mem_write_o, 1'b1);
    next_cyc();
    exp_wa.push_back(32'h14);
    exp_wd.push_back(32'h114);
    @(negedge clk_i);
    chk_b("t2_accept", Stall_o, 1'b0);
    chk_b("t2_no_drain_on_accept", mem_write_o, 1'b0);
    next_cyc();
    idle_until_empty();

`ifdef STORE_FWD_EN
    // 3: youngest matching store is forwarded, head drains alongside
    store(32'h8, 32'h11);
    store(32'h8, 32'h22);
    drive(1'b0, 1'b1, 32'h8, 32'h0);
    exp_rd.push_back(32'h22);
    @(negedge clk_i);
    chk_b("t3_no_stall", Stall_o, 1'b0);
    chk_b("t3_no_mem_read", mem_read_o, 1'b0);
    chk("t3_fwd_data", Readdata_o, 32'h22);
    next_cyc();
    idle_until_empty();
`else
    // 4: matching load stalls until the buffer no longer holds the address
    store(32'h8, 32'h11);
    store(32'hC, 32'h33);
    drive(1'b0, 1'b1, 32'hC, 32'h0);
    exp_rd.push_back(32'h33);
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      if (!Stall_o) break;
      stalls++;
      next_cyc();
    end
    chk("t4_stall_cycles", 32'(stalls), 32'd2);
    chk_b("t4_mem_read", mem_read_o, 1'b1);
    next_cyc();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    chk_b("t4_empty", Empty_o, 1'b1);
`endif

    // 5: non-matching load goes to memory, nothing drains that cycle
    store(32'h20, 32'h55);
    store(32'h24, 32'h66);
    drive(1'b0, 1'b1, 32'h40, 32'h0);
    exp_rd.push_back(32'hD000_0040);
    @(negedge clk_i);
    chk_b("t5_mem_read", mem_read_o, 1'b1);
    chk_b("t5_no_drain", mem_write_o, 1'b0);
    chk_b("t5_no_stall", Stall_o, 1'b0);
    chk("t5_mem_addr", mem_addr_o, 32'h40);
    next_cyc();
    chk_b("t5_still_buffered", Empty_o, 1'b0);
    // read+write together: store wins, load ignored
    drive(1'b1, 1'b1, 32'h30, 32'h77);
    exp_wa.push_back(32'h30);
    exp_wd.push_back(32'h77);
    @(negedge clk_i);
    chk_b("t5_rw_no_read", mem_read_o, 1'b0);
    chk_b("t5_rw_no_stall", Stall_o, 1'b0);
    next_cyc();
    idle_until_empty();

    // 6: reset mid-cycle discards pending stores
    store(32'h50, 32'h1);
    store(32'h54, 32'h2);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    rst_i = 1'b0;
    #1;
    chk_b("t6_empty_now", Empty_o, 1'b1);
    chk_b("t6_no_write", mem_write_o, 1'b0);
    exp_wa.delete();
    exp_wd.delete();
    exp_rd.delete();
    next_cyc();
    next_cyc();
    rst_i = 1'b1;
    repeat (5) next_cyc();
    chk_b("t6_empty_after", Empty_o, 1'b1);
    chk_b("t6_mem50_unchanged", wr_valid[20], 1'b0);
    chk_b("t6_mem54_unchanged", wr_valid[21], 1'b0);

    chk("sb_writes_left", 32'(exp_wa.size()), 32'd0);
    chk("sb_reads_left", 32'(exp_rd.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
